// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package arb_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    // FSM encoding, kept as plain constants for compatibility with older tools
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ADDR = 2'd1;
    localparam state_t STRB = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side and memory-side signals of the arbiter bundled as one interface.
// The slave modport is the arbiter's view; master is the view of masters + memory.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_we;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_re;
    logic              mem_we;

    modport slave (
        input  req, m0_addr, m0_wdata, m0_we, m1_addr, m1_wdata, m1_we, mem_rdata,
        output gnt, ack, rdata, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output req, m0_addr, m0_wdata, m0_we, m1_addr, m1_wdata, m1_we, mem_rdata,
        input  gnt, ack, rdata, mem_addr, mem_wdata, mem_re, mem_we
    );

endinterface

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Combinational winner selection for the arbiter.
// Build option: define ARB_ROUND_ROBIN_EN to alternate owners on simultaneous requests;
// otherwise master 0 has fixed priority.
module arb_grant_sel
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

`ifdef ARB_ROUND_ROBIN_EN
    // Contention goes to whoever did not own the bus last; a lone requester always wins
    always_comb begin
        winner = OWNER_M0;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req == 2'b10) begin
            winner = OWNER_M1;
        end
    end
`else
    // last_owner is still tracked by the parent but plays no part in fixed priority
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Master 0 wins whenever it requests
    always_comb begin
        winner = OWNER_M0;
        if (req == 2'b10) begin
            winner = OWNER_M1;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: grants one master at a time and runs a fixed
// ADDR / STRB (1+WAIT_STATES) / DONE sequence on the shared memory bus.
// Optional macro ARB_ROUND_ROBIN_EN (handled in arb_grant_sel) selects round-robin.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic            clk,
    input logic            rst,
    mem_bus_arbiter_if.slave bus
);

    if (WAIT_STATES > (1 << WAIT_CNT_W) - 1) begin : g_bad_wait_states
        $error("mem_bus_arbiter: WAIT_STATES must be in 0..15");
    end

    state_t                state_q, state_d;
    logic                  owner_q;
    logic                  last_owner_q;
    logic [ADDR_W-1:0]     addr_l;
    logic [DATA_W-1:0]     wdata_l;
    logic                  we_l;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  winner;

    arb_grant_sel u_grant_sel (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    // Next-state: IDLE is always visited between transactions
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req != 2'b00) state_d = ADDR;
            ADDR: state_d = STRB;
            STRB: if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant-time latches, wait counter, read capture and owner history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWNER_M0;
            last_owner_q <= OWNER_M1;
            addr_l       <= '0;
            wdata_l      <= '0;
            we_l         <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        owner_q <= winner;
                        addr_l  <= winner ? bus.m1_addr  : bus.m0_addr;
                        wdata_l <= winner ? bus.m1_wdata : bus.m0_wdata;
                        we_l    <= winner ? bus.m1_we    : bus.m0_we;
                    end
                end
                ADDR: cnt_q <= WAIT_CNT_W'(WAIT_STATES);
                STRB: begin
                    if (cnt_q == '0) begin
                        if (!we_l) rdata_q <= bus.mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: last_owner_q <= owner_q;
                default: ;
            endcase
        end
    end

    // Bus outputs decoded from state; mem_we is also gated by rst so it drops at once
    always_comb begin
        bus.gnt       = (state_q != IDLE) ? owner_onehot(owner_q) : 2'b00;
        bus.ack       = (state_q == DONE) ? owner_onehot(owner_q) : 2'b00;
        bus.rdata     = rdata_q;
        bus.mem_addr  = addr_l;
        bus.mem_wdata = wdata_l;
        bus.mem_re    = !((state_q != IDLE) && we_l);
        bus.mem_we    = rst && (state_q == STRB) && we_l;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit-address / 8-bit-data memory bus between two masters: master 0 (CPU load/store port) and master 1 (DMA/peripheral engine).
- Runs a fixed address/strobe/hold sequence per transaction, so memory sees the same re/we discipline the CPU uses for STA.
- Sits between the masters and the top-level memory/tristate buffer.
- Returns read data and a one-cycle ack to the owning master.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- WAIT_STATES, 0, extra strobe cycles per transaction (0-15).

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous active-low reset
- req  in  2  request per master; bit n = master n
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_we  in  1  master 0 direction: 1 = write, 0 = read
- m1_addr  in  ADDR_W  master 1 address
- m1_wdata  in  DATA_W  master 1 write data
- m1_we  in  1  master 1 direction
- gnt  out  2  one-hot owner indicator for the active transaction
- ack  out  2  one-cycle completion pulse to the owner
- rdata  out  DATA_W  captured read data, broadcast to both masters
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data; top level drives it when mem_re=0
- mem_rdata  in  DATA_W  memory read data
- mem_re  out  1  1 = memory drives bus (read/idle); 0 = arbiter drives bus
- mem_we  out  1  write strobe, active high

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; gnt=0; ack=0; rdata=0; mem_addr=0; mem_wdata=0.
  - mem_re=1; mem_we=0; wait counter=0; last_owner=1.
  - Reset during STRB drops mem_we combinationally with rst. The transaction is abandoned with no ack.
- State machine:
  - IDLE: all outputs idle. If req!=0, select winner w, latch w's addr/wdata/we, owner=w, go to ADDR.
  - ADDR (1 cycle): gnt[owner]=1; mem_addr=latched addr; mem_re=~we_l; mem_we=0; load counter with WAIT_STATES.
  - STRB (1+WAIT_STATES cycles): write: mem_we=1 and mem_re=0. Read: mem_re=1. Counter decrements each cycle. On the last cycle of a read, rdata<=mem_rdata.
  - DONE (1 cycle): mem_we=0; address and data still held; ack[owner]=1; last_owner=owner. Go to IDLE.
- Latency, uncontended: req sampled in IDLE -> ack asserted 3+WAIT_STATES cycles later. Minimum transaction period is 4+WAIT_STATES cycles, since IDLE is always visited between transactions.
- Address and write data are latched at grant. Master inputs may change after gnt rises.
- Once granted, the transaction completes even if req drops; ack still pulses.
- A master holding req after ack is treated as a new request.
- Arbitration, default: fixed priority, master 0 wins when both request. Master 1 can starve.
- gnt is one-hot or zero, never 2'b11.
- ack is asserted only in DONE, for exactly one cycle.
- rdata holds its value until the next read capture. It is not modified by writes.
- Counter width is 4 bits. WAIT_STATES>15 is illegal (elaboration check).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous req=2'b11, grant the master != last_owner. With a single requester, grant it.
- Undefined: fixed priority as above; last_owner is still tracked but unused for selection.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, ADDR, STRB, DONE}
  - OWNER_M0/OWNER_M1 constants
  - WAIT_CNT_W=4
- One sub-module: arb_grant_sel. It is combinational and maps req, last_owner -> winner. The ARB_ROUND_ROBIN_EN macro is confined to it.
- The FSM, latches and wait counter stay in mem_bus_arbiter.

Test Plan:
- Reset mid-write: assert rst low during STRB of a write to 16'h1234.
  -> mem_we=0 immediately; gnt=0; no ack; mem_re=1.
- Single read: WAIT_STATES=0, master 0 reads 16'h0100, memory returns 8'hA5.
  -> gnt=2'b01 for 3 cycles; ack[0] pulses 3 cycles after grant; rdata=8'hA5.
- Single write: master 1 writes 8'h3C to 16'hFFFF with WAIT_STATES=2.
  -> mem_we high for exactly 3 cycles; mem_re=0 ADDR-DONE; mem_wdata=8'h3C; ack[1] once.
- Contention, fixed priority: both req held high for 4 transactions.
  -> all 4 grants go to master 0; ack[1] never asserts.
- Contention, ARB_ROUND_ROBIN_EN defined: both req held for 4 transactions.
  -> grants alternate M0, M1, M0, M1 (last_owner=1 after reset); acks alternate.
- Req withdrawn after grant: master 1 drops req in ADDR while master 0 is idle.
  -> transaction completes; ack[1] pulses; arbiter returns to IDLE with no further grant.
